inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
// - Fetch stage directly upstream of inst_mem: owns the PC and drives inst_mem.addr every cycle.
// - Pairs the registered instruction returned by inst_mem (1-cycle read latency) with its PC.
// - Presents {pc, inst, valid} to decode and handles stall, redirect (branch/jump) and halt.
// PARAMETERS
// - ADDR_WIDTH  my_pkg  PC / instruction-address width in bits.
// - DATA_WIDTH  my_pkg  instruction width in bits (32).
// - RESET_PC    my_pkg  boot address; default 'h0000_0000; must be word-aligned.
// PORTS
// - clk          in   1           the single clock; all state updates on posedge clk.
// - rst          in   1           reset; synchronous, active-high.
// - stall_i      in   1           decode cannot accept this cycle; hold the current output.
// - redirect_i   in   1           taken branch/jump; restart fetch at redirect_pc_i.
// - redirect_pc_i in  ADDR_WIDTH  redirect target.
// - halt_i       in   1           stop fetching (ebreak / end of simulation).
// - mem_addr_o   out  ADDR_WIDTH  combinational address to inst_mem.addr.
// - mem_inst_i   in   DATA_WIDTH  inst_mem.inst; registered, so it is valid one cycle after mem_addr_o.
// - if_pc_o      out  ADDR_WIDTH  PC of if_inst_o.
// - if_inst_o    out  DATA_WIDTH  = mem_inst_i while if_valid_o=1, else NOP_INST.
// - if_valid_o   out  1           if_pc_o / if_inst_o form a live instruction.
// - if_exc_o     out  1           misaligned fetch; exists only with the macro, tied 0 without it.
// BEHAVIOUR
// - Reset: rst=1 at a posedge forces state<=BOOT, pc_q<=RESET_PC, valid_q<=0, exc_q<=0.
//   - Reset beats all other inputs, including mid-stall and mid-redirect.
//   - Reset outputs: if_pc_o=RESET_PC, if_inst_o=NOP_INST, if_valid_o=0, if_exc_o=0.
// - pc_q holds the address issued in the previous cycle, so mem_inst_i is the instruction for pc_q.
// - State BOOT: mem_addr_o=RESET_PC; next cycle pc_q=RESET_PC, valid_q=1, state=RUN.
// - State RUN: mem_addr_o is selected by priority redirect > halt > stall > sequential.
//   - redirect_i=1: mem_addr_o=redirect_pc_i; pc_q<=redirect_pc_i; valid_q stays 1.
//     - The current output is wrong-path; decode kills it. No bubble is inserted.
//   - halt_i=1: mem_addr_o=pc_q; valid_q<=0; state<=HALT.
//   - stall_i=1: mem_addr_o=pc_q. The memory re-reads the held instruction, so the outputs stay
//     identical next cycle. No skid buffer is needed.
//   - Otherwise: mem_addr_o=pc_q+4; pc_q<=pc_q+4.
// - State HALT: mem_addr_o=pc_q; if_valid_o=0; stall_i and halt_i are ignored.
//   - Only redirect_i leaves HALT: pc_q<=redirect_pc_i, valid_q<=1, state<=RUN.
// - Arithmetic: pc_q+4 is unsigned modulo 2^ADDR_WIDTH.
//   - 'hFFFF_FFFC wraps to 0 with no flag.
//   - Addresses beyond MEM_INST_DEPTH are a software error and are not checked.
// - Latency: one cycle from mem_addr_o to the matching if_inst_o. Throughput is 1 instr/cycle.
// - Simultaneous redirect_i and stall_i: redirect wins; decode must not assert both for a live
//   branch it has not yet consumed.
// CONFIGURATION
// - Macro FETCH_MISALIGN_EXC_EN.
// - Defined, on redirect_pc_i[1:0]!=2'b00:
//   - Next cycle: mem_addr_o=redirect_pc_i unmodified; pc_q<=redirect_pc_i; if_exc_o=1;
//     if_valid_o=1; if_inst_o=NOP_INST.
//   - The following cycle: state<=HALT, if_exc_o drops to 0.
// - Not defined: redirect_pc_i[1:0] is forced to 2'b00 before use; if_exc_o is tied 0.
// STRUCTURE
// - my_pkg gains: RESET_PC; NOP_INST='h0000_0013; typedef enum logic [1:0] {BOOT,RUN,HALT} fetch_state_t.
// - The module is flat; the next-PC mux is a single always_comb. No sub-module is warranted.
// TESTING
// - Reset, then 4 free cycles (mem word n = 'h100+n):
//   - Required: BOOT, then pc 0,4,8; inst 'h100,'h101,'h102; valid rises in cycle 2.
// - Stall 3 cycles at pc=8:
//   - Required: if_pc_o=8 and if_inst_o=mem[8] held; mem_addr_o=8 while stalled.
//   - Required: pc=12 on the first cycle after release.
// - Redirect to 'h40 while pc=12:
//   - Required: next cycle pc='h40, inst=mem['h40], valid=1, no bubble.
// - Redirect and stall together:
//   - Required: redirect taken; halt_i then parks with valid=0 and ignores stall.
//   - Required: redirect to 'h80 resumes at 'h80.
// - rst asserted during a stall at pc='h20:
//   - Required: next cycle BOOT, valid=0; then pc=RESET_PC.
// - Macro on, redirect to 'h42:
//   - Required: exc=1, inst=NOP_INST, pc='h42, then HALT.
//   - Required: macro off, same stimulus -> pc='h40, no exception.

Source files
------------

// File: rtl/my_pkg.sv
// Shared fetch-stage definitions: address/data widths, boot address,
// the canonical NOP encoding and the fetch FSM state type.
package my_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;

  // Boot address; must be word-aligned.
  localparam logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'('h0000_0000);

  // addi x0, x0, 0
  localparam logic [DATA_WIDTH-1:0] NOP_INST = DATA_WIDTH'('h0000_0013);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch stage sitting directly upstream of inst_mem.
// Owns the PC, drives inst_mem.addr combinationally every cycle and pairs the
// registered instruction coming back (1-cycle latency) with the PC it belongs to.
// Handles stall, redirect (branch/jump) and halt.
//
// Optional feature: define FETCH_MISALIGN_EXC_EN to raise if_exc_o on a
// redirect target that is not word-aligned (the stage then parks in HALT).
// Without it the low two bits of the redirect target are cleared and
// if_exc_o is tied low.
module inst_fetch
  import my_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  input  logic                  halt_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_inst_i,
  output logic [ADDR_WIDTH-1:0] if_pc_o,
  output logic [DATA_WIDTH-1:0] if_inst_o,
  output logic                  if_valid_o,
  output logic                  if_exc_o
);

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  valid_q;
  logic                  exc_q;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  misaligned;

`ifdef FETCH_MISALIGN_EXC_EN
  assign redirect_pc = redirect_pc_i;
  assign misaligned  = |redirect_pc_i[1:0];
`else
  assign redirect_pc = redirect_pc_i & ~ADDR_WIDTH'(3);
  assign misaligned  = 1'b0;
`endif

  // Next fetch address: redirect > halt > stall > sequential while running.
  always_comb begin
    mem_addr_o = pc_q;
    case (state)
      BOOT: mem_addr_o = RESET_PC;
      RUN: begin
        if (exc_q)                  mem_addr_o = pc_q;
        else if (redirect_i)        mem_addr_o = redirect_pc;
        else if (halt_i || stall_i) mem_addr_o = pc_q;
        else                        mem_addr_o = pc_q + ADDR_WIDTH'(4);
      end
      HALT: begin
        if (redirect_i) mem_addr_o = redirect_pc;
      end
      default: mem_addr_o = pc_q;
    endcase
  end

  // Fetch FSM and the registered PC/valid/exception that accompany mem_inst_i.
  // pc_q always captures the address just issued, so mem_inst_i is the word for pc_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      exc_q   <= 1'b0;
    end else begin
      pc_q <= mem_addr_o;
      case (state)
        BOOT: begin
          valid_q <= 1'b1;
          state   <= RUN;
        end
        RUN: begin
          if (exc_q) begin
            exc_q   <= 1'b0;
            valid_q <= 1'b0;
            state   <= HALT;
          end else if (redirect_i) begin
            valid_q <= 1'b1;
            exc_q   <= misaligned;
          end else if (halt_i) begin
            valid_q <= 1'b0;
            state   <= HALT;
          end
        end
        HALT: begin
          if (redirect_i) begin
            valid_q <= 1'b1;
            exc_q   <= misaligned;
            state   <= RUN;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  assign if_pc_o    = pc_q;
  assign if_valid_o = valid_q;
  assign if_inst_o  = (valid_q && !exc_q) ? mem_inst_i : NOP_INST;

`ifdef FETCH_MISALIGN_EXC_EN
  assign if_exc_o = exc_q;
`else
  assign if_exc_o = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios with literal
// expectations followed by randomized stimulus compared every cycle
// against a behavioural model of the fetch stage.
module tb_inst_fetch;
  import my_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  stall_i = 1'b0;
  logic                  redirect_i = 1'b0;
  logic [ADDR_WIDTH-1:0] redirect_pc_i = '0;
  logic                  halt_i = 1'b0;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_inst_i = '0;
  logic [ADDR_WIDTH-1:0] if_pc_o;
  logic [DATA_WIDTH-1:0] if_inst_o;
  logic                  if_valid_o;
  logic                  if_exc_o;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  inst_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .halt_i       (halt_i),
    .mem_addr_o   (mem_addr_o),
    .mem_inst_i   (mem_inst_i),
    .if_pc_o      (if_pc_o),
    .if_inst_o    (if_inst_o),
    .if_valid_o   (if_valid_o),
    .if_exc_o     (if_exc_o)
  );

  always #5 clk = ~clk;

  // Memory contents: word n holds 'h100 + n.
  function automatic logic [31:0] word(input logic [31:0] addr);
    return 32'h100 + (addr >> 2);
  endfunction

  // Registered-read instruction memory.
  always @(posedge clk) mem_inst_i <= word(mem_addr_o);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = booting, 1 = running, 2 = parked
  int          m_mode = 0;
  logic [31:0] m_pc = '0;
  logic        m_valid = 1'b0;
  logic        m_exc = 1'b0;
  bit          chk_en = 1'b0;

  function automatic logic [31:0] target(input logic [31:0] raw);
`ifdef FETCH_MISALIGN_EXC_EN
    return raw;
`else
    return raw & 32'hFFFF_FFFC;
`endif
  endfunction

  function automatic logic misal(input logic [31:0] raw);
`ifdef FETCH_MISALIGN_EXC_EN
    return raw[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_addr();
    if (m_mode == 0) return RESET_PC;
    if (m_exc) return m_pc;
    if (redirect_i) return target(redirect_pc_i);
    if (m_mode == 1 && !halt_i && !stall_i) return m_pc + 32'd4;
    return m_pc;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_pc = RESET_PC; m_valid = 1'b0; m_exc = 1'b0; chk_en = 1'b1;
    end else if (m_mode == 0) begin
      m_mode = 1; m_valid = 1'b1;
    end else if (m_exc) begin
      m_exc = 1'b0; m_valid = 1'b0; m_mode = 2;
    end else if (redirect_i) begin
      m_pc = target(redirect_pc_i); m_valid = 1'b1; m_exc = misal(redirect_pc_i); m_mode = 1;
    end else if (m_mode == 1 && halt_i) begin
      m_valid = 1'b0; m_mode = 2;
    end else if (m_mode == 1 && !stall_i) begin
      m_pc = m_pc + 32'd4;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_addr",  mem_addr_o, exp_addr());
      check("model_pc",    if_pc_o, m_pc);
      check("model_valid", 32'(if_valid_o), 32'(m_valid));
      check("model_exc",   32'(if_exc_o), 32'(m_exc));
      check("model_inst",  if_inst_o, (m_valid && !m_exc) ? word(m_pc) : NOP_INST);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                            input logic valid);
    check({tag, "_pc"}, if_pc_o, pc);
    check({tag, "_inst"}, if_inst_o, inst);
    check({tag, "_valid"}, 32'(if_valid_o), 32'(valid));
  endtask

  initial begin
    // reset
    step(); step();
    expect_out("reset", 32'h0, NOP_INST, 1'b0);
    check("reset_exc", 32'(if_exc_o), 32'h0);
    rst = 1'b0;
    #1 check("boot_addr", mem_addr_o, 32'h0);

    // free run: BOOT, then pc 0,4,8
    step(); expect_out("run0", 32'h0, 32'h100, 1'b1);
    step(); expect_out("run1", 32'h4, 32'h101, 1'b1);
    step(); expect_out("run2", 32'h8, 32'h102, 1'b1);

    // stall 3 cycles at pc=8
    stall_i = 1'b1;
    #1 check("stall_addr", mem_addr_o, 32'h8);
    for (int i = 0; i < 3; i++) begin
      step(); expect_out("stall", 32'h8, 32'h102, 1'b1);
    end
    stall_i = 1'b0;
    step(); expect_out("release", 32'hC, 32'h103, 1'b1);

    // redirect to 'h40 while pc=12
    redirect_i = 1'b1; redirect_pc_i = 32'h40;
    step(); expect_out("redir", 32'h40, 32'h110, 1'b1);

    // redirect and stall together
    redirect_pc_i = 32'h60; stall_i = 1'b1;
    step(); expect_out("redir_stall", 32'h60, 32'h118, 1'b1);
    redirect_i = 1'b0; halt_i = 1'b1;
    step(); expect_out("halt", 32'h60, NOP_INST, 1'b0);
    halt_i = 1'b0;
    #1 check("halt_addr", mem_addr_o, 32'h60);
    step(); expect_out("halt_hold", 32'h60, NOP_INST, 1'b0);
    stall_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h80;
    step(); expect_out("resume", 32'h80, 32'h120, 1'b1);
    redirect_i = 1'b0;
    step(); expect_out("resume_seq", 32'h84, 32'h121, 1'b1);

    // reset during a stall at 'h20
    redirect_i = 1'b1; redirect_pc_i = 32'h20;
    step(); redirect_i = 1'b0; stall_i = 1'b1;
    step(); expect_out("pre_rst", 32'h20, 32'h108, 1'b1);
    rst = 1'b1;
    step(); expect_out("rst_stall", RESET_PC, NOP_INST, 1'b0);
    rst = 1'b0; stall_i = 1'b0;
    step(); expect_out("post_rst", RESET_PC, 32'h100, 1'b1);

    // misaligned redirect to 'h42
    redirect_i = 1'b1; redirect_pc_i = 32'h42;
    step(); redirect_i = 1'b0;
`ifdef FETCH_MISALIGN_EXC_EN
    expect_out("misal", 32'h42, NOP_INST, 1'b1);
    check("misal_exc", 32'(if_exc_o), 32'h1);
    step(); expect_out("misal_halt", 32'h42, NOP_INST, 1'b0);
    check("misal_exc_drop", 32'(if_exc_o), 32'h0);
`else
    expect_out("misal", 32'h40, 32'h110, 1'b1);
    check("misal_exc", 32'(if_exc_o), 32'h0);
    step(); expect_out("misal_next", 32'h44, 32'h111, 1'b1);
`endif

    // PC wrap at the top of the address space
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8;
    step(); redirect_i = 1'b0;
    expect_out("wrap0", 32'hFFFF_FFF8, 32'h4000_00FE, 1'b1);
    step(); expect_out("wrap1", 32'hFFFF_FFFC, 32'h4000_00FF, 1'b1);
    step(); expect_out("wrap2", 32'h0, 32'h100, 1'b1);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 99) < 2);
      redirect_i    = ($urandom_range(0, 7) == 0);
      halt_i        = ($urandom_range(0, 15) == 0);
      stall_i       = ($urandom_range(0, 3) == 0);
      redirect_pc_i = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      step();
    end
    rst = 1'b0; redirect_i = 1'b0; halt_i = 1'b0; stall_i = 1'b0;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
